// File: rtl/ether_rx.sv
// RMII receive framer: strips preamble/SFD, delays payload dibits by 16 so the
// FCS is never emitted, and checks the CRC-32 residue at end of frame.
module ether_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        done,
  output logic        fcs_ok,
  output logic [1:0]  err,
  output logic [10:0] byte_count
);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_e;

  localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

  state_e       state_q,      state_d;
  logic [4:0]   pre_cnt_q,    pre_cnt_d;
  logic [31:0]  dly_q,        dly_d;
  logic [31:0]  crc_q,        crc_d;
  logic [13:0]  dib_cnt_q,    dib_cnt_d;
  logic         axiov_q,      axiov_d;
  logic [1:0]   axiod_q,      axiod_d;
  logic         done_q,       done_d;
  logic         fcs_ok_q,     fcs_ok_d;
  logic [1:0]   err_q,        err_d;
  logic [10:0]  byte_count_q, byte_count_d;

  logic         runt;
  logic         misaligned;
  logic [11:0]  payload_bytes;

  // Non-reflected shift register fed in wire order; this form makes the
  // good-frame residue read directly as 0xC704DD7B.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic b);
    crc_step = {crc[30:0], 1'b0} ^ ({32{crc[31] ^ b}} & CRC_POLY);
  endfunction

  // A runt is reported as runt only; alignment is meaningless without a full FCS.
  assign runt          = (dib_cnt_q < 14'd16);
  assign misaligned    = !runt && (dib_cnt_q[1:0] != 2'b00);
  assign payload_bytes = dib_cnt_q[13:2] - 12'd4;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    dly_d        = dly_q;
    crc_d        = crc_q;
    dib_cnt_d    = dib_cnt_q;
    axiov_d      = 1'b0;
    axiod_d      = 2'b00;
    done_d       = 1'b0;
    fcs_ok_d     = 1'b0;
    err_d        = 2'b00;
    byte_count_d = '0;

    unique case (state_q)
      WAIT_IDLE: begin
        if (!axiiv) state_d = IDLE;
      end

      IDLE: begin
        if (axiiv) begin
          if (axiid == 2'b01) begin
            state_d   = PREAMBLE;
            pre_cnt_d = 5'd1;
          end else begin
            state_d = DROP;
          end
        end
      end

      PREAMBLE: begin
        if (!axiiv) begin
          state_d = IDLE;
        end else begin
          unique case (axiid)
            2'b01: if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
            2'b11: begin
              if (pre_cnt_q >= 5'd3) begin
                state_d   = DATA;
                dly_d     = '0;
                crc_d     = CRC_INIT;
                dib_cnt_d = '0;
              end else begin
                state_d = DROP;
              end
            end
            default: state_d = DROP;
          endcase
        end
      end

      DATA: begin
        if (axiiv) begin
          dly_d = {dly_q[29:0], axiid};
          crc_d = crc_step(crc_step(crc_q, axiid[0]), axiid[1]);
          if (dib_cnt_q != '1) dib_cnt_d = dib_cnt_q + 14'd1;
          if (!runt) begin
            axiov_d = 1'b1;
            axiod_d = dly_q[31:30];
          end
        end else begin
          state_d      = IDLE;
          done_d       = 1'b1;
          err_d        = {runt, misaligned};
          fcs_ok_d     = !runt && !misaligned && (crc_q == CRC_RESIDUE);
          byte_count_d = runt ? 11'd0
                       : (payload_bytes[11] ? 11'h7FF : payload_bytes[10:0]);
        end
      end

      DROP: begin
        if (!axiiv) state_d = IDLE;
      end

      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the delay line is cleared on reset as well as on DATA entry so
      // no stale dibits can ever reach axiod.
      state_q      <= WAIT_IDLE;
      pre_cnt_q    <= '0;
      dly_q        <= '0;
      crc_q        <= CRC_INIT;
      dib_cnt_q    <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      done_q       <= 1'b0;
      fcs_ok_q     <= 1'b0;
      err_q        <= 2'b00;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      dly_q        <= dly_d;
      crc_q        <= crc_d;
      dib_cnt_q    <= dib_cnt_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      done_q       <= done_d;
      fcs_ok_q     <= fcs_ok_d;
      err_q        <= err_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign done       = done_q;
  assign fcs_ok     = fcs_ok_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_ether_rx.sv
// Directed bench for ether_rx: frames are built with a bytewise reflected
// CRC-32 model and the received stream and end-of-frame status are checked.
module tb_ether_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic        axiov;
  logic [1:0]  axiod;
  logic        done;
  logic        fcs_ok;
  logic [1:0]  err;
  logic [10:0] byte_count;

  ether_rx dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .done       (done),
    .fcs_ok     (fcs_ok),
    .err        (err),
    .byte_count (byte_count)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor
  typedef struct {
    int          cyc;
    logic        fcs_ok;
    logic [1:0]  err;
    logic [10:0] bc;
  } done_t;

  done_t      done_log[$];
  done_t      mon_rec;
  logic [1:0] rx_q[$];
  int         first_ov_cyc = -1;

  always @(negedge clk) begin
    if (axiov) begin
      if (rx_q.size() == 0) first_ov_cyc = cyc;
      rx_q.push_back(axiod);
    end
    if (done) begin
      mon_rec.cyc    = cyc;
      mon_rec.fcs_ok = fcs_ok;
      mon_rec.err    = err;
      mon_rec.bc     = byte_count;
      done_log.push_back(mon_rec);
    end
  end

  // Frame construction
  logic [1:0] tx[$];
  logic [7:0] pay[$];
  int         hdr_len;
  int         data_start_cyc;
  int         fall_cyc;

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) tx.push_back(b[2*k +: 2]);
  endtask

  function automatic logic [31:0] crc32_ref();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (pay[i]) begin
      c = c ^ {24'h0, pay[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n_pre dibits of 01 followed by 11, payload 0..n_bytes-1, FCS, extra 10 dibits
  task automatic build_frame(input int n_pre, input int n_bytes, input int flip, input int extra);
    logic [31:0] fcs;
    tx.delete();
    pay.delete();
    repeat (n_pre) tx.push_back(2'b01);
    tx.push_back(2'b11);
    hdr_len = tx.size();
    for (int i = 0; i < n_bytes; i++) begin
      pay.push_back(8'(i));
      push_byte(8'(i));
    end
    fcs = crc32_ref();
    if (flip >= 0) fcs[flip] = ~fcs[flip];
    for (int k = 0; k < 4; k++) push_byte(fcs[8*k +: 8]);
    repeat (extra) tx.push_back(2'b10);
  endtask

  task automatic send(input int n_dib, input int gap);
    int n;
    n = (n_dib < 0) ? tx.size() : n_dib;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = tx[i];
      if (i == hdr_len) data_start_cyc = cyc;
    end
    @(negedge clk);
    axiiv    = 1'b0;
    axiid    = 2'b00;
    fall_cyc = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    done_log.delete();
    first_ov_cyc = -1;
  endtask

  task automatic check_payload(input string tag);
    logic [7:0] b;
    check({tag, "_len"}, rx_q.size(), pay.size() * 4);
    for (int i = 0; i < pay.size() && 4*i + 3 < rx_q.size(); i++) begin
      b = {rx_q[4*i+3], rx_q[4*i+2], rx_q[4*i+1], rx_q[4*i]};
      check({tag, "_byte"}, b, pay[i]);
    end
  endtask

  task automatic check_done(input string tag, input logic exp_fcs,
                            input logic [1:0] exp_err, input logic [10:0] exp_bc);
    check({tag, "_ndone"}, done_log.size(), 1);
    if (done_log.size() > 0) begin
      check({tag, "_done_cyc"}, done_log[0].cyc, fall_cyc + 1);
      check({tag, "_fcs_ok"},   done_log[0].fcs_ok, exp_fcs);
      check({tag, "_err"},      done_log[0].err, exp_err);
      check({tag, "_bc"},       done_log[0].bc, exp_bc);
    end
  endtask

  initial begin
    int fa;
    int i;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_axiov", axiov, 0);
    check("rst_axiod", axiod, 0);
    check("rst_done", done, 0);
    check("rst_fcs_ok", fcs_ok, 0);
    check("rst_err", err, 0);
    check("rst_bc", byte_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Good 60-byte frame
    clear_mon();
    build_frame(31, 60, -1, 0);
    send(-1, 4);
    check_payload("good");
    check_done("good", 1'b1, 2'b00, 11'd60);
    check("good_latency", first_ov_cyc - data_start_cyc, 17);

    // One FCS bit flipped
    clear_mon();
    build_frame(31, 60, 13, 0);
    send(-1, 4);
    check_payload("badfcs");
    check_done("badfcs", 1'b0, 2'b00, 11'd60);

    // Bad preamble 01 01 10
    clear_mon();
    build_frame(31, 60, -1, 0);
    tx[2] = 2'b10;
    send(-1, 4);
    check("badpre_ov", rx_q.size(), 0);
    check("badpre_ndone", done_log.size(), 0);

    // SFD after only two preamble dibits
    clear_mon();
    build_frame(2, 60, -1, 0);
    send(-1, 4);
    check("shortpre_ov", rx_q.size(), 0);
    check("shortpre_ndone", done_log.size(), 0);

    // Minimum accepted preamble (three 01 before 11)
    clear_mon();
    build_frame(3, 60, -1, 0);
    send(-1, 4);
    check_payload("minpre");
    check_done("minpre", 1'b1, 2'b00, 11'd60);

    // Runt: 10 dibits after SFD
    clear_mon();
    build_frame(31, 60, -1, 0);
    send(hdr_len + 10, 4);
    check("runt_ov", rx_q.size(), 0);
    check_done("runt", 1'b0, 2'b10, 11'd0);

    // Empty payload: exactly 16 dibits of FCS
    clear_mon();
    build_frame(31, 0, -1, 0);
    send(-1, 4);
    check("empty_ov", rx_q.size(), 0);
    check_done("empty", 1'b1, 2'b00, 11'd0);

    // Two trailing dibits
    clear_mon();
    build_frame(31, 60, -1, 2);
    send(-1, 4);
    check("extra_len", rx_q.size(), 242);
    check_done("extra", 1'b0, 2'b01, 11'd60);

    // Back-to-back frames: second starts in the cycle done is high
    clear_mon();
    build_frame(31, 8, -1, 0);
    send(-1, 0);
    fa = fall_cyc;
    build_frame(31, 12, -1, 0);
    send(-1, 4);
    check("b2b_len", rx_q.size(), 80);
    check("b2b_ndone", done_log.size(), 2);
    if (done_log.size() == 2) begin
      check("b2b_cyc0", done_log[0].cyc, fa + 1);
      check("b2b_fcs0", done_log[0].fcs_ok, 1);
      check("b2b_bc0", done_log[0].bc, 8);
      check("b2b_fcs1", done_log[1].fcs_ok, 1);
      check("b2b_bc1", done_log[1].bc, 12);
    end

    // Reset mid-payload with axiiv held high
    clear_mon();
    build_frame(31, 60, -1, 0);
    for (i = 0; i < hdr_len + 100; i++) begin
      @(negedge clk);
      axiiv = 1'b1;
      axiid = tx[i];
    end
    @(negedge clk);
    rst   = 1'b1;
    axiid = tx[i];
    i++;
    @(negedge clk);
    check("midrst_axiov", axiov, 0);
    check("midrst_axiod", axiod, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err, 0);
    check("midrst_bc", byte_count, 0);
    rst = 1'b0;
    rx_q.delete();
    for (; i < tx.size(); i++) begin
      axiid = tx[i];
      @(negedge clk);
    end
    axiiv = 1'b0;
    axiid = 2'b00;
    repeat (4) @(negedge clk);
    check("midrst_rest_ov", rx_q.size(), 0);
    check("midrst_ndone", done_log.size(), 0);

    clear_mon();
    build_frame(31, 60, -1, 0);
    send(-1, 4);
    check_payload("after_rst");
    check_done("after_rst", 1'b1, 2'b00, 11'd60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
